// File: rtl/piradip_axi4mmlite_cmd_manager_if.sv
// AXI4-Lite link between a manager and a register-file subordinate.
// The manager modport drives address/data/valid; the subordinate modport drives ready/response.
interface piradip_axi4mmlite_cmd_manager_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/piradip_axi4mmlite_cmd_manager.sv
// Single-outstanding AXI4-Lite manager: one local command in, one AXI read or write out,
// one response back. Every output is a flop; protection bits are a constant.
module piradip_axi4mmlite_cmd_manager #(
  parameter int          ADDR_WIDTH     = 8,
  parameter int          DATA_WIDTH     = 32,
  parameter logic [2:0]  PROT           = 3'b000,
  parameter logic [15:0] ERR_COUNT_INIT = 16'h0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [15:0]             err_count,
  piradip_axi4mmlite_cmd_manager_if.master m_axi
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_RSP   = 3'd5
  } state_t;

  state_t state_r;
  logic   aw_done_s;
  logic   w_done_s;

  // Error responses (resp[1] set) bump the counter, which sticks at all-ones.
  function automatic logic [15:0] err_count_next(input logic [15:0] count, input logic [1:0] resp);
    if (resp[1] && (count != 16'hFFFF)) begin
      return count + 16'd1;
    end else begin
      return count;
    end
  endfunction

  assign m_axi.awprot = PROT;
  assign m_axi.arprot = PROT;

  // A write channel is done once its valid has dropped or is being accepted this cycle.
  always_comb begin
    aw_done_s = !m_axi.awvalid || m_axi.awready;
    w_done_s  = !m_axi.wvalid  || m_axi.wready;
  end

  // Transaction sequencer with all port outputs held in this block's flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= {DATA_WIDTH{1'b0}};
      rsp_resp      <= 2'b00;
      err_count     <= ERR_COUNT_INIT;
      m_axi.awaddr  <= {ADDR_WIDTH{1'b0}};
      m_axi.awvalid <= 1'b0;
      m_axi.wdata   <= {DATA_WIDTH{1'b0}};
      m_axi.wstrb   <= {(DATA_WIDTH/8){1'b0}};
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.araddr  <= {ADDR_WIDTH{1'b0}};
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              m_axi.awaddr  <= cmd_addr;
              m_axi.wdata   <= cmd_wdata;
              m_axi.wstrb   <= cmd_wstrb;
              m_axi.awvalid <= 1'b1;
              m_axi.wvalid  <= 1'b1;
              state_r       <= ST_WR;
            end else begin
              m_axi.araddr  <= cmd_addr;
              m_axi.arvalid <= 1'b1;
              state_r       <= ST_RADDR;
            end
          end
        end
        ST_WR: begin
          // AW and W complete independently, in either order or together.
          if (m_axi.awvalid && m_axi.awready) begin
            m_axi.awvalid <= 1'b0;
          end
          if (m_axi.wvalid && m_axi.wready) begin
            m_axi.wvalid <= 1'b0;
          end
          if (aw_done_s && w_done_s) begin
            m_axi.bready <= 1'b1;
            state_r      <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (m_axi.bvalid && m_axi.bready) begin
            m_axi.bready <= 1'b0;
            rsp_write    <= 1'b1;
            rsp_rdata    <= {DATA_WIDTH{1'b0}};
            rsp_resp     <= m_axi.bresp;
            rsp_valid    <= 1'b1;
            err_count    <= err_count_next(err_count, m_axi.bresp);
            state_r      <= ST_RSP;
          end
        end
        ST_RADDR: begin
          if (m_axi.arvalid && m_axi.arready) begin
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b1;
            state_r       <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (m_axi.rvalid && m_axi.rready) begin
            m_axi.rready <= 1'b0;
            rsp_write    <= 1'b0;
            rsp_rdata    <= m_axi.rdata;
            rsp_resp     <= m_axi.rresp;
            rsp_valid    <= 1'b1;
            err_count    <= err_count_next(err_count, m_axi.rresp);
            state_r      <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          // Unreachable encodings fall back to a clean idle with no channel asserted.
          state_r       <= ST_IDLE;
          cmd_ready     <= 1'b1;
          rsp_valid     <= 1'b0;
          m_axi.awvalid <= 1'b0;
          m_axi.wvalid  <= 1'b0;
          m_axi.bready  <= 1'b0;
          m_axi.arvalid <= 1'b0;
          m_axi.rready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piradip_axi4mmlite_cmd_manager.sv
// Bench for the AXI4-Lite command manager: directed commands against a delay-configurable
// subordinate, with expected responses queued at issue and checked by a separate monitor.
module tb_piradip_axi4mmlite_cmd_manager;

  logic        clk;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] err_count;

  logic        c2_valid, c2_ready, c2_write;
  logic [7:0]  c2_addr;
  logic [31:0] c2_wdata;
  logic [3:0]  c2_wstrb;
  logic        r2_valid, r2_write;
  logic [31:0] r2_rdata;
  logic [1:0]  r2_resp;
  logic [15:0] err_count2;

  piradip_axi4mmlite_cmd_manager_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) ifc ();
  piradip_axi4mmlite_cmd_manager_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) ifc2 ();

  piradip_axi4mmlite_cmd_manager #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .PROT(3'b000)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
    .m_axi(ifc)
  );

  // Second instance starts its error counter near saturation.
  piradip_axi4mmlite_cmd_manager #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .PROT(3'b000),
                                   .ERR_COUNT_INIT(16'hFFFE)) dut2 (
    .clk(clk), .reset(reset),
    .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_write(c2_write),
    .cmd_addr(c2_addr), .cmd_wdata(c2_wdata), .cmd_wstrb(c2_wstrb),
    .rsp_valid(r2_valid), .rsp_ready(1'b1), .rsp_write(r2_write),
    .rsp_rdata(r2_rdata), .rsp_resp(r2_resp), .err_count(err_count2),
    .m_axi(ifc2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          acc;
    int          lat;
  } exp_t;
  exp_t q[$];

  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  sub_resp = 2'b00;
  logic [31:0] sub_rdata = 32'd0;
  logic [7:0]  exp_addr = 8'd0;
  logic [31:0] exp_wdata = 32'd0;
  logic [3:0]  exp_wstrb = 4'd0;
  bit aw_hs_p, w_hs_p, ar_hs_p, b_hs_p, r_hs_p;
  bit aw_act, w_act, ar_act, aw_got, w_got, ar_got;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  int s_aw, s_w, s_b, s_ar, s_r;
  bit rsp_prev = 1'b0;

  int          awd_tab [3] = '{0, 4, 2};
  int          wd_tab  [3] = '{4, 0, 2};
  logic [3:0]  st_tab  [3] = '{4'h1, 4'hC, 4'h5};
  logic [1:0]  rr_tab  [3] = '{2'b10, 2'b11, 2'b00};
  logic [31:0] rd_tab  [3] = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Subordinate model: evaluated on falling edges, drives its outputs for the next rising edge.
  initial begin
    ifc.awready = 1'b0; ifc.wready = 1'b0; ifc.bvalid = 1'b0; ifc.bresp = 2'b00;
    ifc.arready = 1'b0; ifc.rvalid = 1'b0; ifc.rdata = 32'd0; ifc.rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (reset) begin
        ifc.awready = 1'b0; ifc.wready = 1'b0; ifc.bvalid = 1'b0;
        ifc.arready = 1'b0; ifc.rvalid = 1'b0;
        aw_hs_p = 0; w_hs_p = 0; ar_hs_p = 0; b_hs_p = 0; r_hs_p = 0;
        aw_act = 0; w_act = 0; ar_act = 0; aw_got = 0; w_got = 0; ar_got = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      end else begin
        if (aw_hs_p) begin
          aw_hs_p = 0; ifc.awready = 1'b0; aw_act = 0; aw_got = 1; n_aw++;
          check("aw_drop", ifc.awvalid, 32'd0);
        end else if (aw_act || ifc.awvalid) begin
          aw_act = 1;
          check("aw_hold", ifc.awvalid, 32'd1);
          check("aw_addr", ifc.awaddr, exp_addr);
          if (aw_cnt >= aw_delay) begin ifc.awready = 1'b1; aw_hs_p = 1; aw_cnt = 0; end
          else aw_cnt++;
        end
        if (w_hs_p) begin
          w_hs_p = 0; ifc.wready = 1'b0; w_act = 0; w_got = 1; n_w++;
          check("w_drop", ifc.wvalid, 32'd0);
        end else if (w_act || ifc.wvalid) begin
          w_act = 1;
          check("w_hold", ifc.wvalid, 32'd1);
          check("w_data", ifc.wdata, exp_wdata);
          check("w_strb", ifc.wstrb, exp_wstrb);
          if (w_cnt >= w_delay) begin ifc.wready = 1'b1; w_hs_p = 1; w_cnt = 0; end
          else w_cnt++;
        end
        if (b_hs_p) begin
          b_hs_p = 0; ifc.bvalid = 1'b0; n_b++;
        end else if (ifc.bvalid) begin
          b_hs_p = ifc.bready;
        end else if (aw_got && w_got) begin
          if (b_cnt >= b_delay) begin
            ifc.bvalid = 1'b1; ifc.bresp = sub_resp; aw_got = 0; w_got = 0; b_cnt = 0;
            b_hs_p = ifc.bready;
          end else b_cnt++;
        end
        if (ar_hs_p) begin
          ar_hs_p = 0; ifc.arready = 1'b0; ar_act = 0; ar_got = 1; n_ar++;
          check("ar_drop", ifc.arvalid, 32'd0);
        end else if (ar_act || ifc.arvalid) begin
          ar_act = 1;
          check("ar_hold", ifc.arvalid, 32'd1);
          check("ar_addr", ifc.araddr, exp_addr);
          if (ar_cnt >= ar_delay) begin ifc.arready = 1'b1; ar_hs_p = 1; ar_cnt = 0; end
          else ar_cnt++;
        end
        if (r_hs_p) begin
          r_hs_p = 0; ifc.rvalid = 1'b0; n_r++;
        end else if (ifc.rvalid) begin
          r_hs_p = ifc.rready;
        end else if (ar_got) begin
          if (r_cnt >= r_delay) begin
            ifc.rvalid = 1'b1; ifc.rdata = sub_rdata; ifc.rresp = sub_resp; ar_got = 0; r_cnt = 0;
            r_hs_p = ifc.rready;
          end else r_cnt++;
        end
      end
    end
  end

  // Free-running subordinate for dut2: everything ready, every read answers SLVERR.
  initial begin
    ifc2.awready = 1'b1; ifc2.wready = 1'b1; ifc2.bvalid = 1'b1; ifc2.bresp = 2'b10;
    ifc2.arready = 1'b1; ifc2.rvalid = 1'b1; ifc2.rdata = 32'hCAFE0000; ifc2.rresp = 2'b10;
  end

  // Response monitor: every cycle rsp_valid is high it must match the head of the queue.
  initial forever begin
    @(negedge clk);
    if (rsp_valid) begin
      if (q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        check("rsp_write", rsp_write, q[0].wr);
        check("rsp_rdata", rsp_rdata, q[0].rdata);
        check("rsp_resp", rsp_resp, q[0].resp);
        if (!rsp_prev && q[0].lat >= 0) check("rsp_latency", cyc - q[0].acc, q[0].lat);
        if (rsp_ready) void'(q.pop_front());
      end
    end
    rsp_prev = rsp_valid;
  end

  task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input logic [31:0] rd, input logic [1:0] resp,
                       input int lat);
    exp_t e;
    bit ok = 1'b0;
    exp_addr = addr; exp_wdata = wd; exp_wstrb = st; sub_rdata = rd; sub_resp = resp;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        e.wr = wr; e.rdata = wr ? 32'd0 : rd; e.resp = resp; e.acc = cyc; e.lat = lat;
        q.push_back(e);
      end
    end
    check("cmd_accept", ok, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (q.size() == 0);
    end
    check("rsp_timeout", done, 32'd1);
  endtask

  task automatic snap();
    s_aw = n_aw; s_w = n_w; s_b = n_b; s_ar = n_ar; s_r = n_r;
  endtask

  task automatic check_beats(input int daw, input int dw, input int db, input int dar, input int dr);
    repeat (2) @(negedge clk);
    check("aw_beats", n_aw - s_aw, daw);
    check("w_beats", n_w - s_w, dw);
    check("b_beats", n_b - s_b, db);
    check("ar_beats", n_ar - s_ar, dar);
    check("r_beats", n_r - s_r, dr);
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'd0; cmd_wdata = 32'd0; cmd_wstrb = 4'd0;
    rsp_ready = 1'b1;
    c2_valid = 1'b0; c2_write = 1'b0; c2_addr = 8'd0; c2_wdata = 32'd0; c2_wstrb = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 32'd1);
    check("rst_rsp_valid", rsp_valid, 32'd0);
    check("rst_err_count", err_count, 32'd0);
    check("rst_valids", {ifc.awvalid, ifc.wvalid, ifc.arvalid}, 32'd0);
    check("rst_readies", {ifc.bready, ifc.rready}, 32'd0);
    check("rst_awaddr", ifc.awaddr, 32'd0);
    check("rst_wdata", ifc.wdata, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_err_count2", err_count2, 32'h0000FFFE);
    @(posedge clk); #1;
    reset = 1'b0;

    // Always-ready write: minimum latency.
    snap();
    issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'd0, 2'b00, 3);
    wait_done();
    check_beats(1, 1, 1, 0, 0);

    // Read with stalled arready and late rvalid.
    snap();
    ar_delay = 5; r_delay = 3;
    issue(1'b0, 8'h24, 32'd0, 4'h0, 32'h12345678, 2'b00, -1);
    wait_done();
    check_beats(0, 0, 0, 1, 1);
    ar_delay = 0; r_delay = 0;

    // AW/W skew: AW first, W first, then together.
    for (int i = 0; i < 3; i++) begin
      snap();
      aw_delay = awd_tab[i]; w_delay = wd_tab[i];
      issue(1'b1, 8'h30 + 8'(i * 4), 32'h11110000 + 32'(i), st_tab[i], 32'd0, 2'b00, -1);
      wait_done();
      check_beats(1, 1, 1, 0, 0);
    end
    aw_delay = 0; w_delay = 0;

    // Error responses feed the counter.
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 8'h80 + 8'(i * 4), 32'd0, 4'h0, rd_tab[i], rr_tab[i], 3);
      wait_done();
    end
    check("err_count_mixed", err_count, 32'd2);

    // Saturation on the preloaded instance.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      c2_valid = 1'b1;
      @(posedge clk); #1;
      c2_valid = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("err_count_sat", err_count2, 32'h0000FFFF);
      check("sat_rsp", {r2_valid, r2_write, r2_resp}, 32'd2);
      check("sat_rdata", r2_rdata, 32'hCAFE0000);
    end

    // Response back-pressure with a new command waiting.
    rsp_ready = 1'b0;
    issue(1'b0, 8'h40, 32'd0, 4'h0, 32'hA5A55A5A, 2'b00, -1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    check("hold_rsp_seen", seen, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h44;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_cmd_ready", cmd_ready, 32'd0);
      check("hold_axi_idle", {ifc.awvalid, ifc.wvalid, ifc.arvalid}, 32'd0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    wait_done();
    check("err_count_after_ok", err_count, 32'd2);

    // Reset while waiting for the write response.
    b_delay = 20;
    issue(1'b1, 8'h50, 32'h0BADF00D, 4'h3, 32'd0, 2'b00, -1);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = ifc.bready;
    end
    check("wresp_reached", seen, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valids", {ifc.awvalid, ifc.wvalid, ifc.arvalid}, 32'd0);
    check("mid_rst_readies", {ifc.bready, ifc.rready}, 32'd0);
    check("mid_rst_cmd_ready", cmd_ready, 32'd1);
    check("mid_rst_rsp_valid", rsp_valid, 32'd0);
    b_delay = 0;
    issue(1'b0, 8'h60, 32'd0, 4'h0, 32'h600D600D, 2'b00, 3);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
